// File: rtl/neander_mem_arbiter_if.sv
// Downstream SPI memory controller request/response bus.
// The arbiter drives it as master; the memory controller (or a bench model) is the slave.
interface neander_mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          mem_req;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_out;
   logic [DW-1:0] mem_data_in;
   logic          mem_ready;

   modport master (
      output mem_req, mem_read, mem_write, mem_addr, mem_data_out,
      input  mem_data_in, mem_ready
   );

   modport slave (
      input  mem_req, mem_read, mem_write, mem_addr, mem_data_out,
      output mem_data_in, mem_ready
   );
endinterface

// File: rtl/neander_mem_arbiter.sv
// Round-robin arbiter giving NCH requesters access to one SPI memory controller.
// Define NEANDER_ARB_TIMEOUT_EN to add a mem_ready watchdog that completes with ch_err.
module neander_mem_arbiter #(
   parameter int NCH         = 2,
   parameter int AW          = 16,
   parameter int DW          = 16,
   parameter int TIMEOUT_CYC = 255,
   localparam int GW         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NCH-1:0]      ch_req,
   input  logic [NCH-1:0]      ch_we,
   input  logic [NCH*AW-1:0]   ch_addr,
   input  logic [NCH*DW-1:0]   ch_wdata,
   output logic [NCH-1:0]      ch_ack,
   output logic [NCH-1:0]      ch_err,
   output logic [DW-1:0]       ch_rdata,
   neander_mem_arbiter_if.master mem,
   output logic                busy,
   output logic [GW-1:0]       grant_id
);

   typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

   state_t        state, state_nxt;
   logic [GW-1:0] last_grant;
   logic [GW-1:0] gnt_sel;
   logic          gnt_vld;
   logic          we_q;
   logic          done;
   logic          tmo;

   // Search starts one past the last served channel and wraps modulo NCH,
   // so a non-power-of-two NCH can never select a missing channel.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_vld = 1'b0;
      gnt_sel = last_grant;
      for (int i = 1; i <= NCH; i++) begin
         idx = int'(last_grant) + i;
         if (idx >= NCH) idx = idx - NCH;
         if (!gnt_vld && ch_req[idx]) begin
            gnt_vld = 1'b1;
            gnt_sel = GW'(idx);
         end
      end
   end

   assign done = (state == REQ) && mem.mem_ready;
   assign busy = (state != IDLE);

`ifdef NEANDER_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] tmo_cnt;
   logic          err_q;

   // Counter holds the number of REQ cycles already completed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                      tmo_cnt <= '0;
      else if (state == IDLE)          tmo_cnt <= '0;
      else if (state == REQ)           tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo = (state == REQ) && !mem.mem_ready && (tmo_cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err_q <= 1'b0;
      else        err_q <= tmo;
   end

   assign ch_err = ch_ack & {NCH{err_q}};
`else
   assign tmo    = 1'b0;
   assign ch_err = '0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_vld) state_nxt = REQ;
         REQ:     if (done || tmo) state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant       <= GW'(NCH - 1);
         grant_id         <= '0;
         we_q             <= 1'b0;
         ch_ack           <= '0;
         ch_rdata         <= '0;
         mem.mem_req      <= 1'b0;
         mem.mem_read     <= 1'b0;
         mem.mem_write    <= 1'b0;
         mem.mem_addr     <= '0;
         mem.mem_data_out <= '0;
      end else begin
         ch_ack <= '0;
         case (state)
            IDLE: if (gnt_vld) begin
               grant_id         <= gnt_sel;
               we_q             <= ch_we[gnt_sel];
               mem.mem_addr     <= ch_addr[gnt_sel*AW +: AW];
               mem.mem_data_out <= ch_wdata[gnt_sel*DW +: DW];
               mem.mem_req      <= 1'b1;
               mem.mem_read     <= ~ch_we[gnt_sel];
               mem.mem_write    <= ch_we[gnt_sel];
            end
            REQ: if (done || tmo) begin
               mem.mem_req      <= 1'b0;
               mem.mem_read     <= 1'b0;
               mem.mem_write    <= 1'b0;
               ch_ack[grant_id] <= 1'b1;
               last_grant       <= grant_id;
               if (!done)      ch_rdata <= '1;
               else if (!we_q) ch_rdata <= mem.mem_data_in;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neander_mem_arbiter.sv
// Directed bench for neander_mem_arbiter (NCH=2, 16-bit bus, TIMEOUT_CYC=8).
module tb_neander_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  ch_req, ch_we, ch_ack, ch_err;
   logic [31:0] ch_addr, ch_wdata;
   logic [15:0] ch_rdata;
   logic        busy;
   logic [0:0]  grant_id;
   int          errors = 0;
   int          checks = 0;

   neander_mem_arbiter_if #(.AW(16), .DW(16)) mem ();

   neander_mem_arbiter #(.NCH(2), .AW(16), .DW(16), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .reset(reset), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
      .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_err(ch_err), .ch_rdata(ch_rdata),
      .mem(mem), .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, mem.mem_req, mem.mem_read, mem.mem_write} !== 4'b0) begin
         errors++; $display("FAIL reset_ctl: got %b exp 0000", {busy, mem.mem_req, mem.mem_read, mem.mem_write});
      end
      checks++;
      if ({ch_ack, ch_err, ch_rdata, grant_id, mem.mem_addr} !== 37'h0) begin
         errors++; $display("FAIL reset_data: ack=%b err=%b rdata=%h gid=%0d addr=%h exp all 0",
                            ch_ack, ch_err, ch_rdata, grant_id, mem.mem_addr);
      end
      reset = 1'b1;
   endtask

   task automatic test_reset_mid_req;
      @(negedge clk);
      ch_req = 2'b10; ch_addr = {16'h0077, 16'h0000};
      @(negedge clk);
      checks++;
      if ({mem.mem_req, grant_id} !== 2'b11) begin
         errors++; $display("FAIL mid_req_grant: got req/gid %b exp 11", {mem.mem_req, grant_id});
      end
      ch_req = 2'b00;
      reset  = 1'b0;
      #1;
      checks++;
      if ({busy, mem.mem_req, mem.mem_read, grant_id, mem.mem_addr} !== 20'h0) begin
         errors++; $display("FAIL mid_req_abort: busy=%b req=%b rd=%b gid=%0d addr=%h exp 0",
                            busy, mem.mem_req, mem.mem_read, grant_id, mem.mem_addr);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (ch_ack !== 2'b00) begin
            errors++; $display("FAIL mid_req_no_ack: got %b exp 00", ch_ack);
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_rr;
      int n;
      int exp_ch;
      ch_addr = {16'h0020, 16'h0010}; ch_we = 2'b00; ch_req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_ch = k % 2;
         n = 0;
         while (!mem.mem_req && n < 10) begin
            @(negedge clk); n++;
         end
         checks++;
         if (n >= 10) begin
            errors++; $display("FAIL rr_timeout: no mem_req within 10 cycles for grant %0d", k);
         end
         checks++;
         if ({31'd0, grant_id} !== exp_ch || mem.mem_addr !== (exp_ch == 1 ? 16'h0020 : 16'h0010)) begin
            errors++; $display("FAIL rr_grant%0d: gid=%0d addr=%h exp gid=%0d", k, grant_id, mem.mem_addr, exp_ch);
         end
         mem.mem_ready = 1'b1; mem.mem_data_in = 16'hC000 + 16'(k);
         @(negedge clk);
         mem.mem_ready = 1'b0;
         checks++;
         if (ch_ack !== (exp_ch == 1 ? 2'b10 : 2'b01) || ch_rdata !== 16'hC000 + 16'(k)) begin
            errors++; $display("FAIL rr_ack%0d: ack=%b rdata=%h exp ch%0d rdata=%h", k, ch_ack, ch_rdata, exp_ch, 16'hC000 + 16'(k));
         end
      end
      ch_req = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_idle_ready;
      mem.mem_ready = 1'b1; mem.mem_data_in = 16'h5555;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({busy, ch_ack} !== 3'b000 || ch_rdata !== 16'hC003) begin
            errors++; $display("FAIL idle_ready: busy=%b ack=%b rdata=%h exp 0 00 c003", busy, ch_ack, ch_rdata);
         end
      end
      mem.mem_ready = 1'b0;
   endtask

   task automatic test_read;
      ch_req = 2'b01; ch_we = 2'b00; ch_addr = {16'h0000, 16'h1234};
      @(negedge clk);
      ch_req = 2'b00; ch_addr = {16'h0000, 16'hFFFF};
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if ({mem.mem_req, mem.mem_read, mem.mem_write} !== 3'b110 || mem.mem_addr !== 16'h1234) begin
            errors++; $display("FAIL read_req_c%0d: req/rd/wr=%b addr=%h exp 110 1234", c,
                               {mem.mem_req, mem.mem_read, mem.mem_write}, mem.mem_addr);
         end
         if (c == 4) begin mem.mem_ready = 1'b1; mem.mem_data_in = 16'hBEEF; end
         @(negedge clk);
      end
      mem.mem_ready = 1'b0;
      checks++;
      if (ch_ack !== 2'b01 || ch_err !== 2'b00 || ch_rdata !== 16'hBEEF || mem.mem_req !== 1'b0) begin
         errors++; $display("FAIL read_ack: ack=%b err=%b rdata=%h req=%b exp 01 00 beef 0", ch_ack, ch_err, ch_rdata, mem.mem_req);
      end
      @(negedge clk);
      checks++;
      if (ch_ack !== 2'b00 || busy !== 1'b0) begin
         errors++; $display("FAIL read_ack_pulse: ack=%b busy=%b exp 00 0", ch_ack, busy);
      end
   endtask

   task automatic test_write;
      ch_req = 2'b01; ch_we = 2'b01; ch_addr = {16'h0000, 16'h0040}; ch_wdata = {16'h0000, 16'hA5A5};
      @(negedge clk);
      ch_req = 2'b00;
      checks++;
      if ({mem.mem_req, mem.mem_read, mem.mem_write} !== 3'b101 || mem.mem_addr !== 16'h0040 || mem.mem_data_out !== 16'hA5A5) begin
         errors++; $display("FAIL write_req: req/rd/wr=%b addr=%h dout=%h exp 101 0040 a5a5",
                            {mem.mem_req, mem.mem_read, mem.mem_write}, mem.mem_addr, mem.mem_data_out);
      end
      mem.mem_ready = 1'b1; mem.mem_data_in = 16'h1111;
      @(negedge clk);
      mem.mem_ready = 1'b0;
      checks++;
      if (ch_ack !== 2'b01 || ch_rdata !== 16'hBEEF) begin
         errors++; $display("FAIL write_ack: ack=%b rdata=%h exp 01 beef", ch_ack, ch_rdata);
      end
      @(negedge clk);
      ch_we = 2'b00;
   endtask

`ifdef NEANDER_ARB_TIMEOUT_EN
   task automatic test_timeout;
      ch_req = 2'b01; ch_addr = {16'h0000, 16'h0100};
      @(negedge clk);
      ch_req = 2'b00;
      for (int c = 1; c <= 8; c++) begin
         checks++;
         if (mem.mem_req !== 1'b1) begin
            errors++; $display("FAIL tmo_hold_c%0d: req=%b exp 1", c, mem.mem_req);
         end
         @(negedge clk);
      end
      checks++;
      if (mem.mem_req !== 1'b0 || ch_ack !== 2'b01 || ch_err !== 2'b01 || ch_rdata !== 16'hFFFF) begin
         errors++; $display("FAIL tmo_expire: req=%b ack=%b err=%b rdata=%h exp 0 01 01 ffff", mem.mem_req, ch_ack, ch_err, ch_rdata);
      end
      @(negedge clk);
      ch_req = 2'b01;
      @(negedge clk);
      ch_req = 2'b00;
      for (int c = 1; c <= 8; c++) begin
         if (c == 8) begin mem.mem_ready = 1'b1; mem.mem_data_in = 16'h1357; end
         @(negedge clk);
      end
      mem.mem_ready = 1'b0;
      checks++;
      if (ch_ack !== 2'b01 || ch_err !== 2'b00 || ch_rdata !== 16'h1357) begin
         errors++; $display("FAIL tmo_ready_wins: ack=%b err=%b rdata=%h exp 01 00 1357", ch_ack, ch_err, ch_rdata);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      reset = 1'b0; ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
      mem.mem_ready = 1'b0; mem.mem_data_in = '0;
      test_reset;
      test_reset_mid_req;
      test_rr;
      test_idle_ready;
      test_read;
      test_write;
`ifdef NEANDER_ARB_TIMEOUT_EN
      test_timeout;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
